cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the TinyCPU core. It consumes instruction_type from the instruction
//  decoder and drives the PC, IR, register-file write and memory strobes through
//  BOOT/FETCH/DECODE/EXEC. Memory uses a req/ready handshake with a wait-timeout, and the block
//  keeps a retired-instruction counter. Sits between the decoder, the register file, the ALU
//  and the single shared instruction/data memory port.
// PARAMETERS
//  T_NOP       0   instruction_type code: no-op
//  T_LOAD_IMM  1   instruction_type code: reg <= zero-extended 16-bit immediate
//  T_LOAD      2   instruction_type code: reg <= mem[addr reg]
//  T_STORE     3   instruction_type code: mem[addr reg] <= data reg
//  T_ALU       4   instruction_type code: res reg <= alu result
//  T_JUMP      5   instruction_type code: PC <= addr reg if cond reg != 0
//  T_HALT      6   instruction_type code: stop
//  MEM_TIMEOUT 16  max consecutive not-ready cycles per access; 0 disables the timeout
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous active-low reset
//  instr_type       in   5   decoder instruction_type (from IR)
//  jump_cond_nz     in   1   1 when the jump condition register value is non-zero
//  mem_ready        in   1   memory completes the current access this cycle
//  mem_req          out  1   memory access request
//  mem_we           out  1   write strobe (valid only with mem_req)
//  mem_addr_sel     out  1   0 = PC, 1 = address register
//  ir_we            out  1   latch memory read data into IR
//  rf_we            out  1   register-file write enable
//  rf_wdata_sel     out  2   0 = immediate, 1 = ALU result, 2 = memory read data
//  pc_inc           out  1   PC <= PC + 1
//  pc_load          out  1   PC <= jump address register
//  halted           out  1   core is stopped (HALTED state)
//  illegal_instr    out  1   sticky: halt caused by an undefined type code
//  mem_timeout      out  1   sticky: halt caused by a memory timeout
//  retired          out  32  count of completed instructions
// BEHAVIOUR
//  - States: BOOT, FETCH, DECODE, EXEC, HALTED. Asynchronous reset forces BOOT, clears
//    retired/wait_cnt/sticky flags. Every output is 0 while in BOOT.
//  - BOOT -> FETCH on the first clock edge after rst_n deasserts.
//  - FETCH: mem_req=1, mem_we=0, addr_sel=0. If mem_ready: ir_we=1 in that cycle, then -> DECODE.
//    Otherwise stay in FETCH.
//  - DECODE: one cycle with no strobes, for register-file read; then -> EXEC.
//  - EXEC, by instr_type:
//    - LOAD_IMM: rf_we=1, sel=0, pc_inc=1 -> FETCH.
//    - ALU: rf_we=1, sel=1, pc_inc=1 -> FETCH.
//    - NOP: pc_inc=1 -> FETCH.
//    - LOAD: mem_req=1, addr_sel=1. Held until mem_ready; on the ready cycle rf_we=1, sel=2,
//      pc_inc=1 -> FETCH.
//    - STORE: mem_req=1, mem_we=1, addr_sel=1. Held until mem_ready; on the ready cycle
//      pc_inc=1 -> FETCH.
//    - JUMP: pc_load=jump_cond_nz, pc_inc=!jump_cond_nz -> FETCH.
//    - HALT: -> HALTED, no strobes.
//    - Any other code: -> HALTED, set illegal_instr.
//  - HALTED: all strobes 0 and halted=1. Stays until reset.
//  - Strobe timing: outputs decode combinationally from state, instr_type and mem_ready.
//    pc_inc and pc_load are mutually exclusive. mem_req stays asserted until ready (no drop).
//  - Timeout: wait_cnt resets to 0 on entry to FETCH or memory-EXEC, and increments each
//    cycle mem_req=1 && !mem_ready. If !mem_ready while wait_cnt==MEM_TIMEOUT-1 -> HALTED
//    with mem_timeout set. mem_ready has priority in that same cycle.
//  - retired += 1 in every cycle with pc_inc|pc_load. It wraps 2^32-1 -> 0. HALT is not
//    counted.
//  - Minimum latency is 3 cycles per instruction (FETCH, DECODE, EXEC) with zero-wait memory.
//  - Reset mid-access drops mem_req asynchronously. No partial state survives.
// TESTING
//  1. Reset, then LOAD_IMM with mem_ready tied 1 -> ir_we on cycle 1, rf_we+sel0+pc_inc on
//     cycle 3, retired=1.
//  2. LOAD, ready delayed 2 cycles in EXEC -> mem_req/addr_sel=1 for 3 cycles,
//     rf_we+sel2+pc_inc only on the 3rd.
//  3. JUMP with jump_cond_nz=1 then 0 -> pc_load then pc_inc, never both. retired +2.
//  4. MEM_TIMEOUT=4, mem_ready=0 in FETCH -> mem_req 4 cycles, then halted=1, mem_timeout=1.
//  5. Type 31 -> halted=1, illegal_instr=1, retired unchanged. rst_n pulse -> BOOT, flags 0.
//  6. Force retired to 32'hFFFF_FFFF, run one NOP -> retired=0. HALT -> halted=1, retired
//     unchanged.

Source files
------------

// File: rtl/cpu_control_fsm_if.sv
// Control-path bundle between the TinyCPU sequencer and its decoder, memory port and datapath.
// master = the sequencer; slave = the surrounding core (or a bench).
interface cpu_control_fsm_if;
  logic [4:0]  instr_type;
  logic        jump_cond_nz;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        rf_we;
  logic [1:0]  rf_wdata_sel;
  logic        pc_inc;
  logic        pc_load;
  logic        halted;
  logic        illegal_instr;
  logic        mem_timeout;
  logic [31:0] retired;

  modport master (
    input  instr_type, jump_cond_nz, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, rf_we, rf_wdata_sel,
           pc_inc, pc_load, halted, illegal_instr, mem_timeout, retired
  );

  modport slave (
    output instr_type, jump_cond_nz, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, rf_we, rf_wdata_sel,
           pc_inc, pc_load, halted, illegal_instr, mem_timeout, retired
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// TinyCPU multi-cycle sequencer: BOOT/FETCH/DECODE/EXEC/HALTED with a memory req/ready
// handshake, per-access wait timeout and a retired-instruction counter.
module cpu_control_fsm #(
  parameter logic [4:0]  T_NOP       = 5'd0,
  parameter logic [4:0]  T_LOAD_IMM  = 5'd1,
  parameter logic [4:0]  T_LOAD      = 5'd2,
  parameter logic [4:0]  T_STORE     = 5'd3,
  parameter logic [4:0]  T_ALU       = 5'd4,
  parameter logic [4:0]  T_JUMP      = 5'd5,
  parameter logic [4:0]  T_HALT      = 5'd6,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst_n,
  cpu_control_fsm_if.master bus
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  // Counter only needs to reach MEM_TIMEOUT-1; the last-value compare is unused when disabled.
  localparam int unsigned     WCW       = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 32'd1);
  localparam logic            TO_EN     = (MEM_TIMEOUT != 32'd0);

  logic [2:0]     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           illegal_q, illegal_d;
  logic           mem_timeout_q, mem_timeout_d;
  logic [31:0]    retired_q, retired_d;

  logic           mem_req_s, mem_we_s, mem_addr_sel_s, ir_we_s, rf_we_s;
  logic [1:0]     rf_wdata_sel_s;
  logic           pc_inc_s, pc_load_s, halted_s, timeout_s;

  // Strobe decode, next state, wait counter, sticky flags and retire counter.
  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    mem_timeout_d  = mem_timeout_q;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_sel_s = 1'b0;
    ir_we_s        = 1'b0;
    rf_we_s        = 1'b0;
    rf_wdata_sel_s = 2'd0;
    pc_inc_s       = 1'b0;
    pc_load_s      = 1'b0;
    halted_s       = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.mem_ready) begin
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (bus.instr_type)
          T_NOP: begin
            pc_inc_s = 1'b1;
            state_d  = S_FETCH;
          end
          T_LOAD_IMM: begin
            rf_we_s  = 1'b1;
            pc_inc_s = 1'b1;
            state_d  = S_FETCH;
          end
          T_ALU: begin
            rf_we_s        = 1'b1;
            rf_wdata_sel_s = 2'd1;
            pc_inc_s       = 1'b1;
            state_d        = S_FETCH;
          end
          T_LOAD: begin
            mem_req_s      = 1'b1;
            mem_addr_sel_s = 1'b1;
            if (bus.mem_ready) begin
              rf_we_s        = 1'b1;
              rf_wdata_sel_s = 2'd2;
              pc_inc_s       = 1'b1;
              state_d        = S_FETCH;
            end else begin
              state_d = S_EXEC;
            end
          end
          T_STORE: begin
            mem_req_s      = 1'b1;
            mem_we_s       = 1'b1;
            mem_addr_sel_s = 1'b1;
            if (bus.mem_ready) begin
              pc_inc_s = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_EXEC;
            end
          end
          T_JUMP: begin
            pc_load_s = bus.jump_cond_nz;
            pc_inc_s  = ~bus.jump_cond_nz;
            state_d   = S_FETCH;
          end
          T_HALT: begin
            state_d = S_HALTED;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALTED;
          end
        endcase
      end
      S_HALTED: begin
        halted_s = 1'b1;
        state_d  = S_HALTED;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase

    // A ready in the last allowed wait cycle still completes the access.
    timeout_s = TO_EN && mem_req_s && !bus.mem_ready && (wait_cnt_q == WAIT_LAST);
    if (timeout_s) begin
      state_d       = S_HALTED;
      mem_timeout_d = 1'b1;
    end else begin
      mem_timeout_d = mem_timeout_q;
    end

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req_s && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    if (pc_inc_s || pc_load_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      wait_cnt_q    <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
      retired_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
      retired_q     <= retired_d;
    end
  end

  assign bus.mem_req       = mem_req_s;
  assign bus.mem_we        = mem_we_s;
  assign bus.mem_addr_sel  = mem_addr_sel_s;
  assign bus.ir_we         = ir_we_s;
  assign bus.rf_we         = rf_we_s;
  assign bus.rf_wdata_sel  = rf_wdata_sel_s;
  assign bus.pc_inc        = pc_inc_s;
  assign bus.pc_load       = pc_load_s;
  assign bus.halted        = halted_s;
  assign bus.illegal_instr = illegal_q;
  assign bus.mem_timeout   = mem_timeout_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scenario bench for cpu_control_fsm: per-cycle expected strobe words go through a queue
// and are compared on the falling edge; retired count is checked after each instruction.
module tb_cpu_control_fsm;

  localparam logic [4:0] T_NOP      = 5'd0;
  localparam logic [4:0] T_LOAD_IMM = 5'd1;
  localparam logic [4:0] T_LOAD     = 5'd2;
  localparam logic [4:0] T_STORE    = 5'd3;
  localparam logic [4:0] T_ALU      = 5'd4;
  localparam logic [4:0] T_JUMP     = 5'd5;
  localparam logic [4:0] T_HALT     = 5'd6;

  // Strobe word: {req, we, addr_sel, ir_we, rf_we, sel[1:0], inc, load, halted, illegal, timeout}
  localparam logic [11:0] B_NONE = 12'h000;
  localparam logic [11:0] B_REQ  = 12'h800;
  localparam logic [11:0] B_WE   = 12'h400;
  localparam logic [11:0] B_AS   = 12'h200;
  localparam logic [11:0] B_IR   = 12'h100;
  localparam logic [11:0] B_RF   = 12'h080;
  localparam logic [11:0] B_SEL2 = 12'h040;
  localparam logic [11:0] B_SEL1 = 12'h020;
  localparam logic [11:0] B_INC  = 12'h010;
  localparam logic [11:0] B_LD   = 12'h008;
  localparam logic [11:0] B_H    = 12'h004;
  localparam logic [11:0] B_ILL  = 12'h002;
  localparam logic [11:0] B_TO   = 12'h001;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [11:0] exp_q[$];

  cpu_control_fsm_if ifc ();

  cpu_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {ifc.mem_req, ifc.mem_we, ifc.mem_addr_sel, ifc.ir_we, ifc.rf_we,
                     ifc.rf_wdata_sel, ifc.pc_inc, ifc.pc_load, ifc.halted,
                     ifc.illegal_instr, ifc.mem_timeout};

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (obs !== B_NONE) begin n_fail++; $display("FAIL reset_strobes: got %h want %h", obs, B_NONE); end
    n_tests++;
    if (ifc.retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %h want 0", ifc.retired); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_imm();
    logic [11:0] ev [3];
    logic [11:0] e;
    ev = '{B_REQ | B_IR, B_NONE, B_RF | B_INC};
    for (int c = 0; c < 3; c++) begin
      ifc.instr_type = T_LOAD_IMM; ifc.mem_ready = 1'b1; ifc.jump_cond_nz = 1'b0;
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL load_imm c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_tests++;
    if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL load_imm_retired: got %0d want %0d", ifc.retired, exp_ret); end
  endtask

  task automatic test_load_wait();
    logic [11:0] ev [5];
    logic        rdy [5];
    logic [11:0] e;
    ev  = '{B_REQ | B_IR, B_NONE, B_REQ | B_AS, B_REQ | B_AS, B_REQ | B_AS | B_RF | B_SEL2 | B_INC};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      ifc.instr_type = T_LOAD; ifc.mem_ready = rdy[c];
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL load_wait c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_tests++;
    if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL load_wait_retired: got %0d want %0d", ifc.retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ev [7];
    logic [4:0]  ty [7];
    logic        rdy [7];
    logic [11:0] e;
    ty  = '{T_ALU, T_ALU, T_ALU, T_STORE, T_STORE, T_STORE, T_STORE};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ev  = '{B_REQ | B_IR, B_NONE, B_RF | B_SEL1 | B_INC,
            B_REQ | B_IR, B_NONE, B_REQ | B_WE | B_AS, B_REQ | B_WE | B_AS | B_INC};
    for (int c = 0; c < 7; c++) begin
      ifc.instr_type = ty[c]; ifc.mem_ready = rdy[c];
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL alu_store c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd2;
    n_tests++;
    if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL alu_store_retired: got %0d want %0d", ifc.retired, exp_ret); end
  endtask

  task automatic test_jump();
    logic [11:0] ev [6];
    logic        cnd [6];
    logic [11:0] e;
    cnd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ev  = '{B_REQ | B_IR, B_NONE, B_LD, B_REQ | B_IR, B_NONE, B_INC};
    for (int c = 0; c < 6; c++) begin
      ifc.instr_type = T_JUMP; ifc.mem_ready = 1'b1; ifc.jump_cond_nz = cnd[c];
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL jump c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
    end
    ifc.jump_cond_nz = 1'b0;
    exp_ret = exp_ret + 32'd2;
    n_tests++;
    if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL jump_retired: got %0d want %0d", ifc.retired, exp_ret); end
  endtask

  task automatic test_timeout();
    logic [11:0] ev [6];
    logic [11:0] e;
    ev = '{B_REQ, B_REQ, B_REQ, B_REQ, B_H | B_TO, B_H | B_TO};
    for (int c = 0; c < 6; c++) begin
      ifc.instr_type = T_NOP; ifc.mem_ready = 1'b0;
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
    end
    n_tests++;
    if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL timeout_retired: got %0d want %0d", ifc.retired, exp_ret); end
  endtask

  task automatic test_reset_mid_access();
    assert_reset();
    n_tests++;
    if (obs !== B_NONE) begin n_fail++; $display("FAIL reset_clears_flags: got %h want %h", obs, B_NONE); end
    n_tests++;
    if (ifc.retired !== 32'd0) begin n_fail++; $display("FAIL reset_clears_retired: got %0d want 0", ifc.retired); end
    exp_ret = 32'd0;
    release_reset();
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== B_REQ) begin n_fail++; $display("FAIL mid_access_req: got %h want %h", obs, B_REQ); end
    @(posedge clk); #1;
    assert_reset();
    n_tests++;
    if (obs !== B_NONE) begin n_fail++; $display("FAIL mid_access_drop: got %h want %h", obs, B_NONE); end
    release_reset();
  endtask

  task automatic test_illegal();
    logic [4:0]  codes [2];
    logic [11:0] ev [4];
    logic [11:0] e;
    codes = '{5'd7, 5'd31};
    ev    = '{B_REQ | B_IR, B_NONE, B_NONE, B_H | B_ILL};
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        ifc.instr_type = codes[k]; ifc.mem_ready = 1'b1;
        exp_q.push_back(ev[c]);
        @(negedge clk);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL illegal_%0d c%0d: got %h want %h", codes[k], c, obs, e); end
        @(posedge clk); #1;
      end
      n_tests++;
      if (ifc.retired !== exp_ret) begin n_fail++; $display("FAIL illegal_%0d_retired: got %0d want %0d", codes[k], ifc.retired, exp_ret); end
      assert_reset();
      n_tests++;
      if (obs !== B_NONE) begin n_fail++; $display("FAIL illegal_%0d_reset: got %h want %h", codes[k], obs, B_NONE); end
      release_reset();
    end
  endtask

  task automatic test_wrap_halt();
    logic [11:0] ev [7];
    logic [4:0]  ty [7];
    logic [11:0] e;
    ty = '{T_NOP, T_NOP, T_NOP, T_HALT, T_HALT, T_HALT, T_HALT};
    ev = '{B_REQ | B_IR, B_NONE, B_INC, B_REQ | B_IR, B_NONE, B_NONE, B_H};
    ifc.mem_ready = 1'b1;
    force dut.retired_q = 32'hFFFF_FFFF;
    for (int c = 0; c < 7; c++) begin
      ifc.instr_type = ty[c];
      exp_q.push_back(ev[c]);
      @(negedge clk);
      e = exp_q.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL wrap_halt c%0d: got %h want %h", c, obs, e); end
      @(posedge clk); #1;
      if (c == 0) begin
        release dut.retired_q;
        n_tests++;
        if (ifc.retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", ifc.retired); end
      end
      if (c == 2) begin
        n_tests++;
        if (ifc.retired !== 32'd0) begin n_fail++; $display("FAIL wrap_to_zero: got %h want 0", ifc.retired); end
      end
    end
    n_tests++;
    if (ifc.retired !== 32'd0) begin n_fail++; $display("FAIL halt_retired: got %h want 0", ifc.retired); end
  endtask

  initial begin
    ifc.instr_type   = T_LOAD_IMM;
    ifc.mem_ready    = 1'b1;
    ifc.jump_cond_nz = 1'b0;
    test_reset();
    test_load_imm();
    test_load_wait();
    test_back_to_back();
    test_jump();
    test_timeout();
    test_reset_mid_access();
    test_illegal();
    test_wrap_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
